ai_core_dispatch: RTL and testbench
===================================

// Module: ai_core_dispatch
// PURPOSE
//  Upstream issue stage for AI_Core. Buffers incoming {instr, data} pairs in a FIFO and
//  issues them one at a time: holds instr/data stable and power_enable high until the
//  core's done, or until a timeout. Returns each core result on a valid/ready output.
//  Results leave strictly in issue order; at most one op is in the core at any time.
// PARAMETERS
//  DEPTH    8   FIFO entries; power of 2, >= 2
//  TIMEOUT  15  WAIT cycles without core_done before the op is retired as an error; 1..255
// PORTS
//  clk              in   1      rising-edge clock
//  reset_n          in   1      synchronous, active-low reset
//  in_valid         in   1      upstream offers an op
//  in_ready         out  1      dispatcher accepts the op this cycle
//  in_instr         in   32     instruction word; [3:0] unit select, [7:4] unit op
//  in_data          in   32     operand
//  flush            in   1      synchronous abort of all queued and in-flight ops
//  core_instr       out  32     to AI_Core.instr (registered)
//  core_data        out  32     to AI_Core.data_in (registered)
//  core_power_en    out  1      to AI_Core.power_enable (registered)
//  core_done        in   1      from AI_Core.done
//  core_result      in   32     from AI_Core.result
//  out_valid        out  1      result available
//  out_ready        in   1      downstream consumes the result
//  out_result       out  32     core result, or 0 on error
//  out_error        out  1      1 = op timed out (no done)
//  fifo_count       out  clog2(DEPTH)+1  queued entries; excludes the in-flight op
// BEHAVIOUR
//  Reset (reset_n=0 at an edge), applied in every state, mid-operation included:
//   FIFO emptied; ptrs and count = 0; state = IDLE; core_instr, core_data = 0;
//   core_power_en = 0; out_valid, out_error = 0; out_result = 0; timer = 0.
//   in_ready = 0 while reset_n = 0.
//  in_ready = reset_n & ~flush & (fifo_count < DEPTH); fifo_count is the registered count.
//  Push occurs when in_valid & in_ready. Ptrs wrap modulo DEPTH.
//  A push and a pop in the same cycle leave the count unchanged.
//  Output handshake: out_* hold stable while out_valid & ~out_ready.
//   out_valid clears on out_valid & out_ready, unless a new result loads at the same edge.
//  The output slot is free when ~out_valid | out_ready.
//  FSM:
//   IDLE:  if FIFO non-empty and the slot is free: pop the head; core_instr/core_data <= head;
//          core_power_en <= 1; timer <= 0; go to ISSUE.
//   ISSUE: exactly 1 cycle; core_done is ignored here (stale); go to WAIT.
//   WAIT:  if core_done: out_result <= core_result; out_error <= 0; out_valid <= 1;
//          core_instr <= 0; core_power_en <= 0; go to IDLE.
//          Else if timer == TIMEOUT-1: out_result <= 0; out_error <= 1; out_valid <= 1;
//          core_instr <= 0; core_power_en <= 0; go to IDLE.
//          Else timer <= timer + 1. Timer is 8 bits, saturating.
//  Min latency: push edge P -> ISSUE at P+1 -> WAIT at P+2 -> out_valid high after edge P+3.
//  Back-to-back throughput: 1 op per 3 cycles when out_ready = 1.
//  flush (lower priority than reset):
//   FIFO emptied; an ISSUE/WAIT op is dropped without output; core_instr = 0;
//   core_power_en = 0; state = IDLE.
//   A pending out_valid is kept. A push in the flush cycle is refused (in_ready = 0).
//  core_done outside WAIT is ignored. core_data is held through ISSUE and WAIT.
//  Invalid unit select (core never asserts done) retires via timeout.
// TESTING
//  T1 push instr=0x11, data=5; core model returns 0xA
//     -> out_valid after edge P+3; out_result=0xA; out_error=0.
//  T2 out_ready=0, push 10 ops back-to-back
//     -> first op completes and is held; next 8 fill the FIFO; fifo_count=8; in_ready=0;
//        10th op waits. Release out_ready -> all 9 results appear in push order.
//  T3 push instr=0x00 (no unit)
//     -> out_valid with out_error=1, out_result=0 after TIMEOUT WAIT cycles (P+2+15).
//  T4 stale done: core model holds done=1 into the next ISSUE
//     -> no early retire; the result is taken only in WAIT.
//  T5 flush in WAIT with 3 entries queued
//     -> no output for any of them; fifo_count=0; core_power_en=0 the next cycle.
//  T6 reset_n=0 mid-WAIT with out_valid=1
//     -> all outputs 0 the next cycle; a new push then completes normally as in T1.

Source files
------------

// File: rtl/ai_core_dispatch.sv
// rtl/ai_core_dispatch.sv - FIFO-buffered single-op issue stage for AI_Core with timeout retire
module ai_core_dispatch #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_data,
    input  logic                     flush,
    output logic [31:0]              core_instr,
    output logic [31:0]              core_data,
    output logic                     core_power_en,
    input  logic                     core_done,
    input  logic [31:0]              core_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_error,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          r_state;
    logic [63:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_timer;
    logic [31:0]     r_core_instr;
    logic [31:0]     r_core_data;
    logic            r_power_en;
    logic            r_out_valid;
    logic [31:0]     r_out_result;
    logic            r_out_error;

    logic            w_slot_free;
    logic            w_push;
    logic            w_pop;
    logic            w_done;
    logic            w_timeout;
    logic            w_load;

    assign w_slot_free = ~r_out_valid | out_ready;
    assign in_ready    = reset_n & ~flush & (r_count < (AW+1)'(DEPTH));
    assign w_push      = in_valid & in_ready;
    // A new op is only launched when the output slot is guaranteed empty afterwards.
    assign w_pop       = (r_state == S_IDLE) & (r_count != '0) & w_slot_free & ~flush;
    assign w_done      = (r_state == S_WAIT) & core_done & ~flush;
    assign w_timeout   = (r_state == S_WAIT) & ~core_done & (r_timer == 8'(TIMEOUT - 1)) & ~flush;
    assign w_load      = w_done | w_timeout;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_instr, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_core_instr <= '0;
            r_core_data  <= '0;
            r_power_en   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_error  <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop)      r_count <= r_count + 1'b1;
                else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            end

            if (w_load) begin
                r_out_valid  <= 1'b1;
                r_out_result <= w_done ? core_result : 32'h0;
                r_out_error  <= ~w_done;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Flush drops the in-flight op but leaves a pending result in the output slot.
            if (flush) begin
                r_state      <= S_IDLE;
                r_core_instr <= '0;
                r_power_en   <= 1'b0;
                r_timer      <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pop) begin
                            r_core_instr <= r_mem[r_rd_ptr][63:32];
                            r_core_data  <= r_mem[r_rd_ptr][31:0];
                            r_power_en   <= 1'b1;
                            r_timer      <= '0;
                            r_state      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (w_load) begin
                            r_core_instr <= '0;
                            r_power_en   <= 1'b0;
                            r_state      <= S_IDLE;
                        end else if (r_timer != 8'hFF) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign core_instr    = r_core_instr;
    assign core_data     = r_core_data;
    assign core_power_en = r_power_en;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_error     = r_out_error;
    assign fifo_count    = r_count;
endmodule

// File: tb/tb_ai_core_dispatch.sv
// tb/tb_ai_core_dispatch.sv - scoreboard bench for ai_core_dispatch with a behavioural AI_Core model
module tb_ai_core_dispatch;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_data = '0;
    logic        flush = 1'b0;
    logic [31:0] core_instr;
    logic [31:0] core_data;
    logic        core_power_en;
    logic        core_done;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_error;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    // Core model state: done after a per-op latency, optionally held one cycle past power-down.
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0;
    int          m_cyc = 0;
    int          m_lat = 1;
    logic        m_hold = 1'b0;
    int          fixed_lat = 0;
    logic        stale_en = 1'b0;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_res = '0;
    logic        prev_err = 1'b0;

    ai_core_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_data(in_data), .flush(flush),
        .core_instr(core_instr), .core_data(core_data), .core_power_en(core_power_en),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .fifo_count(fifo_count)
    );

    assign core_done   = m_done;
    assign core_result = m_res;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_power_en) begin
            m_cyc  <= m_cyc + 1;
            m_hold <= 1'b0;
            if (m_cyc + 1 >= m_lat && core_instr[3:0] != 4'h0) begin
                m_done <= 1'b1;
                m_res  <= core_data << core_instr[7:4];
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_cyc <= 0;
            m_lat <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 6));
            if (m_done && stale_en && !m_hold) begin
                m_hold <= 1'b1;
            end else begin
                m_done <= 1'b0;
                m_hold <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [32:0] expect_of(input logic [31:0] ins, input logic [31:0] dat);
        if (ins[3:0] == 4'h0) return {32'h0, 1'b1};
        return {dat << ins[7:4], 1'b0};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (prev_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(out_result), 64'(prev_res));
            chk("hold_error", 64'(out_error), 64'(prev_err));
        end
        prev_hold = reset_n & out_valid & ~out_ready;
        prev_res  = out_result;
        prev_err  = out_error;
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result=%0h error=%0b, required no output", out_result, out_error);
            end else begin
                e = exp_q.pop_front();
                chk("out_result", 64'(out_result), 64'(e[32:1]));
                chk("out_error", 64'(out_error), 64'(e[0]));
            end
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] dat);
        int n = 0;
        in_valid = 1'b1;
        in_instr = ins;
        in_data  = dat;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
        end else begin
            exp_q.push_back(expect_of(ins, dat));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 2000 && (exp_q.size() != 0 || out_valid || fifo_count != 0 || core_power_en)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_and_check();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("rst_core_instr", 64'(core_instr), 64'd0);
        chk("rst_core_data", 64'(core_data), 64'd0);
        chk("rst_power_en", 64'(core_power_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_error", 64'(out_error), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_fifo_count", 64'(fifo_count), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic t1_latency();
        fixed_lat = 1;
        out_ready = 1'b1;
        push(32'h11, 32'd5);
        @(posedge clk); #1;
        chk("t1_valid_p1", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_valid_p2", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_valid_p3", 64'(out_valid), 64'd1);
        chk("t1_result", 64'(out_result), 64'hA);
        chk("t1_error", 64'(out_error), 64'd0);
        drain();
        fixed_lat = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int sent;
        logic [31:0] ins;
        logic [31:0] dat;

        reset_and_check();

        t1_latency();

        // Back-pressure: one result held, FIFO fills to DEPTH, tenth op must wait.
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(32'h1 | 32'((i % 4) << 4), $urandom);
        in_valid = 1'b1;
        in_instr = 32'h21;
        in_data  = 32'h1234;
        repeat (25) @(negedge clk);
        chk("t2_fifo_full", 64'(fifo_count), 64'd8);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_held_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(32'h21, 32'h1234);
        drain();

        // Invalid unit select retires through the timeout.
        push(32'h0, 32'h55);
        repeat (TIMEOUT + 1) @(posedge clk);
        #1;
        chk("t3_valid_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_error", 64'(out_error), 64'd1);
        chk("t3_result", 64'(out_result), 64'd0);
        drain();

        // Stale done from op A must not retire op B during ISSUE.
        stale_en  = 1'b1;
        fixed_lat = 1;
        push(32'h31, 32'h3);
        push(32'h20, 32'h9);
        drain();
        fixed_lat = 0;

        // Flush while op 1 waits and three more are queued.
        for (int i = 0; i < 4; i++) push(32'h0, 32'(i));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'h11;
        in_data  = 32'h7;
        @(negedge clk);
        chk("t5_in_ready_flush", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        chk("t5_fifo_count", 64'(fifo_count), 64'd0);
        chk("t5_power_en", 64'(core_power_en), 64'd0);
        chk("t5_core_instr", 64'(core_instr), 64'd0);
        repeat (30) @(posedge clk);
        #1;
        chk("t5_no_output", 64'(out_valid), 64'd0);

        // Reset with a held result and queued ops, then reset mid-WAIT.
        out_ready = 1'b0;
        push(32'h11, 32'h7);
        push(32'h0, 32'h1);
        push(32'h12, 32'h2);
        repeat (12) @(posedge clk);
        #1;
        reset_and_check();
        out_ready = 1'b1;
        push(32'h0, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        chk("t6_in_wait", 64'(core_power_en), 64'd1);
        reset_and_check();
        t1_latency();

        // Randomized traffic with random back-pressure.
        sent = 0;
        for (int cyc = 0; cyc < 3000 && sent < 40; cyc++) begin
            ins       = {24'h0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            dat       = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = ins;
            in_data   = dat;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(expect_of(ins, dat));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
